// File: rtl/decoder_pkg.sv
// Shared definitions for the quadrature decoder and its downstream consumers.
// Holds the default count width, the signed count type and the velocity FSM states.
package decoder_pkg;
    localparam int CNT_W = 16;

    typedef logic signed [CNT_W-1:0] cnt_t;

    typedef enum logic {PRIME, RUN} vel_state_t;
endpackage

// File: rtl/cnt_sampler.sv
// Brings an asynchronous multi-bit bus into the clock domain. A value is only
// accepted once two consecutive samples agree, so skewed mid-transition codes are dropped.
module cnt_sampler #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    logic [W-1:0] s1, s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            dout <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (s1 == s2)
                dout <= s2;
        end
    end
endmodule

// File: rtl/quad_velocity.sv
// Differences the sampled decoder count over a fixed window of clock cycles and
// emits a saturated signed velocity; windows that span an index reset are discarded.
module quad_velocity #(
    parameter int CNT_W  = decoder_pkg::CNT_W,
    parameter int VEL_W  = 16,
    parameter int WINDOW = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt,
    input  logic             z,
    output logic [VEL_W-1:0] vel,
    output logic             vel_valid,
    output logic             vel_sat,
    output logic             idx_pulse
);
    import decoder_pkg::*;

    localparam int WC_W = $clog2(WINDOW);
    localparam logic signed [CNT_W-1:0] VMAX = {{(CNT_W-VEL_W+1){1'b0}}, {(VEL_W-1){1'b1}}};
    localparam logic signed [CNT_W-1:0] VMIN = {{(CNT_W-VEL_W+1){1'b1}}, {(VEL_W-1){1'b0}}};

    logic [CNT_W-1:0]        stable, prev;
    logic [WC_W-1:0]         wcnt;
    logic                    z1, z_s, idx_seen, tc;
    logic signed [CNT_W-1:0] delta;
    logic [VEL_W-1:0]        vel_clip;
    logic                    clip, do_vel, do_idx;
    vel_state_t              state, state_nx;

    cnt_sampler #(.W(CNT_W)) u_smp (
        .clk  (clk),
        .rst  (rst),
        .din  (cnt),
        .dout (stable)
    );

    assign tc = (wcnt == WC_W'(WINDOW-1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z1       <= 1'b0;
            z_s      <= 1'b0;
            wcnt     <= '0;
            idx_seen <= 1'b0;
        end else begin
            z1  <= z;
            z_s <= z1;
            wcnt <= tc ? '0 : wcnt + WC_W'(1);
            // Clear at window end wins; z_s on the tc cycle is handled by the FSM directly.
            if (tc)
                idx_seen <= 1'b0;
            else if (z_s)
                idx_seen <= 1'b1;
        end
    end

    // Modulo subtraction gives correct wrap-around for moderate motion per window.
    always_comb begin
        delta    = stable - prev;
        clip     = 1'b0;
        vel_clip = delta[VEL_W-1:0];
        if (delta > VMAX) begin
            clip     = 1'b1;
            vel_clip = VMAX[VEL_W-1:0];
        end else if (delta < VMIN) begin
            clip     = 1'b1;
            vel_clip = VMIN[VEL_W-1:0];
        end
    end

    always_comb begin
        state_nx = state;
        do_vel   = 1'b0;
        do_idx   = 1'b0;
        if (tc) begin
            state_nx = RUN;
            if (state == RUN) begin
                if (idx_seen || z_s)
                    do_idx = 1'b1;
                else
                    do_vel = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= PRIME;
            prev      <= '0;
            vel       <= '0;
            vel_sat   <= 1'b0;
            vel_valid <= 1'b0;
            idx_pulse <= 1'b0;
        end else begin
            state     <= state_nx;
            vel_valid <= do_vel;
            idx_pulse <= do_idx;
            if (do_vel) begin
                vel     <= vel_clip;
                vel_sat <= clip;
            end
            if (tc)
                prev <= stable;
        end
    end
endmodule

// File: tb/tb_quad_velocity.sv
// Randomised and directed check of quad_velocity (16-bit and 8-bit velocity variants)
// against a window-level reference model of the sampler, index discard and saturation.
module tb_quad_velocity;
    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cnt;
    logic        z;
    logic [15:0] vel_a;
    logic [7:0]  vel_b;
    logic        valid_a, sat_a, idx_a;
    logic        valid_b, sat_b, idx_b;

    int errors = 0;
    int checks = 0;

    quad_velocity #(.CNT_W(16), .VEL_W(16), .WINDOW(W)) dut (
        .clk(clk), .rst(rst), .cnt(cnt), .z(z),
        .vel(vel_a), .vel_valid(valid_a), .vel_sat(sat_a), .idx_pulse(idx_a)
    );

    quad_velocity #(.CNT_W(16), .VEL_W(8), .WINDOW(W)) dut8 (
        .clk(clk), .rst(rst), .cnt(cnt), .z(z),
        .vel(vel_b), .vel_valid(valid_b), .vel_sat(sat_b), .idx_pulse(idx_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference model: per-edge input history since reset release.
    logic [15:0] hist[$];
    logic        zh[$];
    int          e;
    bit          primed;
    logic [15:0] prev_m;
    int          m_vel16, m_sat16, m_vel8, m_sat8, m_valid, m_idx;
    int          first_valid;

    function automatic logic [15:0] h(int i);
        return (i < 0) ? 16'h0 : hist[i];
    endfunction

    function automatic logic zz(int i);
        return (i < 0) ? 1'b0 : zh[i];
    endfunction

    // Value held by the sampler after edge n: the latest value that was seen on
    // two consecutive edges, taken one edge after it became confirmed.
    function automatic logic [15:0] stab(int n);
        for (int m = n; m >= 0; m--)
            if (h(m-1) == h(m-2)) return h(m-2);
        return 16'h0;
    endfunction

    task automatic model_reset();
        hist.delete();
        zh.delete();
        e = 0;
        primed = 0;
        prev_m = 16'h0;
        m_vel16 = 0; m_sat16 = 0; m_vel8 = 0; m_sat8 = 0;
        m_valid = 0; m_idx = 0;
        first_valid = -1;
    endtask

    task automatic model_edge();
        logic [15:0] sv, d;
        bit          disc;
        int          di;
        m_valid = 0;
        m_idx   = 0;
        if (e % W == W-1) begin
            sv = stab(e-1);
            if (!primed) begin
                primed = 1;
            end else begin
                disc = 0;
                for (int i = e-W-1; i <= e-2; i++) disc |= zz(i);
                if (disc) begin
                    m_idx = 1;
                end else begin
                    d  = sv - prev_m;
                    di = int'($signed(d));
                    m_valid = 1;
                    m_vel16 = di;
                    m_sat16 = 0;
                    if (di > 127)       begin m_vel8 = 127;  m_sat8 = 1; end
                    else if (di < -128) begin m_vel8 = -128; m_sat8 = 1; end
                    else                begin m_vel8 = di;   m_sat8 = 0; end
                end
            end
            prev_m = sv;
        end
    endtask

    task automatic cyc(input logic [15:0] v, input logic zv);
        @(negedge clk);
        cnt = v;
        z   = zv;
        hist.push_back(v);
        zh.push_back(zv);
        @(posedge clk);
        #1;
        model_edge();
        if (valid_a && first_valid < 0) first_valid = e;
        chk("valid16", int'(valid_a), m_valid);
        chk("idx16",   int'(idx_a),   m_idx);
        chk("vel16",   int'($signed(vel_a)), m_vel16);
        chk("sat16",   int'(sat_a),   m_sat16);
        chk("valid8",  int'(valid_b), m_valid);
        chk("idx8",    int'(idx_b),   m_idx);
        chk("vel8",    int'($signed(vel_b)), m_vel8);
        chk("sat8",    int'(sat_b),   m_sat8);
        e++;
    endtask

    task automatic hold(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) cyc(v, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_vel16"},  int'(vel_a),   0);
        chk({tag, "_valid"},  int'(valid_a), 0);
        chk({tag, "_sat"},    int'(sat_a),   0);
        chk({tag, "_idx"},    int'(idx_a),   0);
        chk({tag, "_vel8"},   int'(vel_b),   0);
        chk({tag, "_sat8"},   int'(sat_b),   0);
    endtask

    initial begin
        logic [15:0] cur;
        int          r;
        model_reset();
        rst = 1'b1;
        cnt = 16'd100;
        z   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;

        // Prime window then forward/backward steps.
        hold(16'd100, 8);
        chk("prime_no_strobe", first_valid, -1);
        hold(16'd100, 2); hold(16'd105, 6);
        chk("fwd", int'($signed(vel_a)), 5);
        hold(16'd105, 2); hold(-16'sd98, 0); hold(16'd98, 6);
        chk("bwd", int'($signed(vel_a)), -7);

        // Wrap-around both ways.
        hold(16'd32765, 8);
        hold(16'h8002, 8);
        chk("wrap_fwd", int'($signed(vel_a)), 5);
        hold(16'd32765, 8);
        chk("wrap_bwd", int'($signed(vel_a)), -5);

        // Index pulse mid-window with count forced to zero.
        hold(16'd32765, 2);
        cyc(16'd0, 1'b1); cyc(16'd0, 1'b1);
        hold(16'd0, 4);
        chk("idx_pulse", int'(idx_a), 1);
        chk("idx_novalid", int'(valid_a), 0);
        chk("idx_hold", int'($signed(vel_a)), -5);
        hold(16'd0, 2); hold(16'd3, 6);
        chk("after_idx", int'($signed(vel_a)), 3);

        // Saturation on the 8-bit variant.
        hold(16'd203, 8);
        chk("sat_pos", int'($signed(vel_b)), 127);
        chk("sat_pos_flag", int'(sat_b), 1);
        hold(-16'sd97, 8);
        chk("sat_neg", int'($signed(vel_b)), -128);

        // One-cycle bogus value never reaches the sampler output.
        hold(-16'sd97, 3); cyc(16'd555, 1'b0); hold(-16'sd97, 4);
        chk("skew", int'($signed(vel_a)), 0);

        // Randomised windows with motion, glitches and index pulses.
        cur = -16'sd97;
        for (int i = 0; i < 20 * W; i++) begin
            r = $urandom_range(0, 9);
            if (r < 3)       cur = cur + 16'($urandom_range(0, 700)) - 16'd350;
            else if (r == 8) cur = 16'($urandom);
            if (r == 9) cyc(cur ^ 16'($urandom_range(1, 65535)), ($urandom_range(0, 29) == 0));
            else        cyc(cur, ($urandom_range(0, 29) == 0));
        end

        // Known move, then reset in cycle 4 of a RUN window.
        hold(cur, 8);
        hold(cur, 2); hold(cur + 16'd9, 6);
        chk("pre_rst", int'($signed(vel_a)), 9);
        hold(cur + 16'd9, 4);
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        hold(16'd50, 8);
        hold(16'd50, 3); hold(16'd60, 5);
        chk("post_rst_vel", int'($signed(vel_a)), 10);
        chk("first_strobe", first_valid, 2*W - 1);
        hold(16'd60, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
